// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the scanning one-hot decoder.
package dec_scan_pkg;

    typedef enum logic [1:0] {
        DIRECT    = 2'b00,
        SCAN_UP   = 2'b01,
        SCAN_DOWN = 2'b10,
        SWEEP     = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sweep_state_e;

    // Prescaler counter width; a single bit is kept even when DIV=1.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/dec_scan_tick.sv
// Prescaler: emits one tick every DIV enabled cycles; clr restarts the count.
module tick_gen
    import dec_scan_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // A clear in the same cycle suppresses the tick so a restart always gets a full period.
    assign tick = en && !clr && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (clr || tick) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dec_scan.sv
// One-hot decoder with direct select, up/down scanning and a single-pass sweep.
module dec_scan
    import dec_scan_pkg::*;
#(
    parameter  int unsigned N   = 3,
    parameter  int unsigned DIV = 4,
    localparam int unsigned M   = 2**N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic [N-1:0] Din,
    input  logic         load,
    output logic [M-1:0] Y,
    output logic [N-1:0] idx,
    output logic         wrap,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] IDX_MAX = N'(M - 1);

    mode_e        mode_s;
    mode_e        mode_q;
    sweep_state_e state_q;
    sweep_state_e state_n;
    logic [N-1:0] idx_n;
    logic [M-1:0] y_n;
    logic         wrap_n;
    logic         done_n;
    logic         busy_n;
    logic         active;
    logic         mode_chg;
    logic         load_acc;
    logic         pen;
    logic         pclr;
    logic         tick;

    assign mode_s   = mode_e'(mode);
    assign mode_chg = (mode_s != mode_q);

    // A load is taken in the scan modes, or in SWEEP only while idle; never on a mode-change cycle.
    assign load_acc = en && load && !mode_chg &&
                      ((mode_s == SCAN_UP) || (mode_s == SCAN_DOWN) ||
                       ((mode_s == SWEEP) && (state_q == IDLE)));
    assign pen      = en && (mode_s != DIRECT);
    assign pclr     = mode_chg || load_acc;

    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (pen),
        .clr  (pclr),
        .tick (tick)
    );

    // Next-state and output computation
    always_comb begin
        idx_n   = idx;
        state_n = state_q;
        wrap_n  = 1'b0;
        done_n  = 1'b0;
        if (en) begin
            if (mode_chg) begin
                state_n = IDLE;
                if (mode_s == DIRECT) begin
                    idx_n = Din;
                end
            end else begin
                case (mode_s)
                    DIRECT: begin
                        idx_n   = Din;
                        state_n = IDLE;
                    end
                    SCAN_UP: begin
                        if (load_acc) begin
                            idx_n = Din;
                        end else if (tick) begin
                            idx_n  = idx + N'(1);
                            wrap_n = (idx == IDX_MAX);
                        end
                    end
                    SCAN_DOWN: begin
                        if (load_acc) begin
                            idx_n = Din;
                        end else if (tick) begin
                            idx_n  = idx - N'(1);
                            wrap_n = (idx == '0);
                        end
                    end
                    SWEEP: begin
                        case (state_q)
                            IDLE: begin
                                if (load_acc) begin
                                    idx_n   = Din;
                                    state_n = RUN;
                                end
                            end
                            RUN: begin
                                if (tick) begin
                                    if (idx == IDX_MAX) begin
                                        state_n = IDLE;
                                        done_n  = 1'b1;
                                    end else begin
                                        idx_n = idx + N'(1);
                                    end
                                end
                            end
                            default: state_n = IDLE;
                        endcase
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
        busy_n = (state_n == RUN);
        // Sweep decode shows only while running before and after the edge, so load and done edges read zero.
        active = en && ((mode_s != SWEEP) || ((state_q == RUN) && (state_n == RUN)));
        y_n    = active ? (M'(1) << idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            Y       <= '0;
            wrap    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            state_q <= IDLE;
            mode_q  <= DIRECT;
        end else begin
            idx     <= idx_n;
            Y       <= y_n;
            wrap    <= wrap_n;
            busy    <= busy_n;
            done    <= done_n;
            state_q <= state_n;
            if (en) begin
                mode_q <= mode_s;
            end
        end
    end

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan (N=3, DIV=4): stimulus queues expected snapshots, monitor checks them.
module tb_dec_scan;
    import dec_scan_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [2:0] din;
    logic       load;
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
    logic       busy;
    logic       done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         e;
        string      name;
        logic [2:0] idx;
        logic [7:0] y;
        logic       w;
        logic       b;
        logic       d;
    } exp_t;

    exp_t sbq[$];

    dec_scan #(.N(3), .DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .Din  (din),
        .load (load),
        .Y    (y),
        .idx  (idx),
        .wrap (wrap),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expect a snapshot after edge number cyc+d.
    task automatic expect_at(input int d, input string nm, input logic [2:0] i,
                             input logic [7:0] yy, input logic w, input logic b, input logic dn);
        exp_t x;
        x.e    = cyc + d;
        x.name = nm;
        x.idx  = i;
        x.y    = yy;
        x.w    = w;
        x.b    = b;
        x.d    = dn;
        sbq.push_back(x);
    endtask

    logic wrap_prev = 1'b0;
    logic done_prev = 1'b0;

    // Monitor: compare every queued snapshot due at this edge, and watch pulse widths.
    always @(negedge clk) begin
        for (int k = sbq.size() - 1; k >= 0; k--) begin
            if (sbq[k].e == cyc) begin
                checks++;
                if ({idx, y, wrap, busy, done} !== {sbq[k].idx, sbq[k].y, sbq[k].w, sbq[k].b, sbq[k].d}) begin
                    errors++;
                    $display("FAIL %s edge %0d: got idx=%0d Y=%b wrap=%b busy=%b done=%b, want idx=%0d Y=%b wrap=%b busy=%b done=%b",
                             sbq[k].name, cyc, idx, y, wrap, busy, done,
                             sbq[k].idx, sbq[k].y, sbq[k].w, sbq[k].b, sbq[k].d);
                end
                sbq.delete(k);
            end
        end
        if (wrap === 1'b1) begin
            checks++;
            if (wrap_prev) begin
                errors++;
                $display("FAIL wrap_width edge %0d: got wrap high 2 cycles, want 1", cyc);
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_prev) begin
                errors++;
                $display("FAIL done_width edge %0d: got done high 2 cycles, want 1", cyc);
            end
        end
        wrap_prev = (wrap === 1'b1);
        done_prev = (done === 1'b1);
    end

    initial begin
        logic [7:0] one;
        logic [2:0] prev;
        one  = 8'd1;
        rst  = 1'b1;
        en   = 1'b0;
        mode = DIRECT;
        din  = 3'd0;
        load = 1'b0;
        adv(2);
        expect_at(0, "reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

        // DIRECT walk: idx follows Din, Y one edge later
        rst  = 1'b0;
        en   = 1'b1;
        prev = 3'd0;
        for (int v = 0; v < 8; v++) begin
            din = 3'(v);
            expect_at(1, "direct_idx", 3'(v), one << prev, 1'b0, 1'b0, 1'b0);
            expect_at(2, "direct_y",   3'(v), one << v,    1'b0, 1'b0, 1'b0);
            adv(2);
            prev = 3'(v);
        end

        // SCAN_UP from 6 through the 7->0 wrap
        mode = SCAN_UP;
        expect_at(1, "up_modechg", 3'd7, 8'h80, 1'b0, 1'b0, 1'b0);
        adv(1);
        load = 1'b1;
        din  = 3'd6;
        expect_at(1,  "up_load",    3'd6, 8'h80, 1'b0, 1'b0, 1'b0);
        expect_at(2,  "up_y6",      3'd6, 8'h40, 1'b0, 1'b0, 1'b0);
        expect_at(4,  "up_hold6",   3'd6, 8'h40, 1'b0, 1'b0, 1'b0);
        expect_at(5,  "up_step7",   3'd7, 8'h40, 1'b0, 1'b0, 1'b0);
        expect_at(6,  "up_y7",      3'd7, 8'h80, 1'b0, 1'b0, 1'b0);
        expect_at(8,  "up_hold7",   3'd7, 8'h80, 1'b0, 1'b0, 1'b0);
        expect_at(9,  "up_wrap",    3'd0, 8'h80, 1'b1, 1'b0, 1'b0);
        expect_at(10, "up_y0",      3'd0, 8'h01, 1'b0, 1'b0, 1'b0);
        expect_at(13, "up_step1",   3'd1, 8'h01, 1'b0, 1'b0, 1'b0);
        adv(1);
        load = 1'b0;
        adv(12);

        // en=0 pause at idx=3 with two prescaler counts left
        load = 1'b1;
        din  = 3'd3;
        expect_at(1,  "en_load",    3'd3, 8'h02, 1'b0, 1'b0, 1'b0);
        expect_at(2,  "en_y3",      3'd3, 8'h08, 1'b0, 1'b0, 1'b0);
        expect_at(4,  "en_off_y0",  3'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_at(13, "en_off_end", 3'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_at(14, "en_back",    3'd3, 8'h08, 1'b0, 1'b0, 1'b0);
        expect_at(15, "en_step4",   3'd4, 8'h08, 1'b0, 1'b0, 1'b0);
        expect_at(16, "en_y4",      3'd4, 8'h10, 1'b0, 1'b0, 1'b0);
        adv(1);
        load = 1'b0;
        adv(2);
        en = 1'b0;
        adv(10);
        en = 1'b1;
        adv(3);

        // SCAN_DOWN with load colliding with a tick
        mode = SCAN_DOWN;
        expect_at(1, "down_modechg", 3'd4, 8'h10, 1'b0, 1'b0, 1'b0);
        adv(4);
        load = 1'b1;
        din  = 3'd2;
        expect_at(1,  "down_load",  3'd2, 8'h10, 1'b0, 1'b0, 1'b0);
        expect_at(2,  "down_y2",    3'd2, 8'h04, 1'b0, 1'b0, 1'b0);
        expect_at(4,  "down_hold2", 3'd2, 8'h04, 1'b0, 1'b0, 1'b0);
        expect_at(5,  "down_step1", 3'd1, 8'h04, 1'b0, 1'b0, 1'b0);
        expect_at(6,  "down_y1",    3'd1, 8'h02, 1'b0, 1'b0, 1'b0);
        expect_at(9,  "down_step0", 3'd0, 8'h02, 1'b0, 1'b0, 1'b0);
        expect_at(13, "down_wrap",  3'd7, 8'h01, 1'b1, 1'b0, 1'b0);
        expect_at(14, "down_y7",    3'd7, 8'h80, 1'b0, 1'b0, 1'b0);
        adv(1);
        load = 1'b0;
        adv(13);

        // SWEEP from 5 with an ignored mid-run load
        mode = SWEEP;
        expect_at(1, "sw_enter", 3'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        adv(1);
        load = 1'b1;
        din  = 3'd5;
        expect_at(1,  "sw_start",   3'd5, 8'h00, 1'b0, 1'b1, 1'b0);
        expect_at(2,  "sw_y5",      3'd5, 8'h20, 1'b0, 1'b1, 1'b0);
        expect_at(5,  "sw_step6",   3'd6, 8'h20, 1'b0, 1'b1, 1'b0);
        expect_at(7,  "sw_reload",  3'd6, 8'h40, 1'b0, 1'b1, 1'b0);
        expect_at(9,  "sw_step7",   3'd7, 8'h40, 1'b0, 1'b1, 1'b0);
        expect_at(12, "sw_hold7",   3'd7, 8'h80, 1'b0, 1'b1, 1'b0);
        expect_at(13, "sw_done",    3'd7, 8'h00, 1'b0, 1'b0, 1'b1);
        expect_at(14, "sw_idle",    3'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        adv(1);
        load = 1'b0;
        adv(5);
        load = 1'b1;
        din  = 3'd1;
        adv(1);
        load = 1'b0;
        adv(7);

        // Reset in the middle of a sweep at idx=6
        load = 1'b1;
        din  = 3'd5;
        expect_at(1, "rs_start", 3'd5, 8'h00, 1'b0, 1'b1, 1'b0);
        adv(1);
        load = 1'b0;
        expect_at(5, "rs_pre", 3'd6, 8'h40, 1'b0, 1'b1, 1'b0);
        adv(5);
        rst = 1'b1;
        expect_at(1, "rs_mid",  3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        expect_at(2, "rs_hold", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        adv(2);
        rst = 1'b0;
        expect_at(1, "rs_after", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        adv(3);

        if (sbq.size() != 0) begin
            errors += sbq.size();
            $display("FAIL unchecked: got %0d pending expectations, want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
